// File: rtl/button_reader.sv
// Push-button front end: per-button 2-FF synchroniser, counter debounce,
// press/release edge pulses and a hold auto-repeat FSM.
module button_reader #(
   parameter int N             = 5,
   parameter int DEB_CYCLES    = 1000000,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_W         = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn_in,
   output logic [N-1:0] btn_state,
   output logic [N-1:0] btn_press,
   output logic [N-1:0] btn_release,
   output logic [N-1:0] btn_repeat,
   output logic         any_press
);

   localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} holdState_t;

   logic [N-1:0] r_sync1;
   logic [N-1:0] r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_in;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_btn
      logic             r_state;
      logic             r_press;
      logic             r_release;
      logic             r_repeat;
      logic [CNT_W-1:0] r_dcnt;
      logic [CNT_W-1:0] r_hcnt;
      holdState_t       r_hold;

      logic             w_stateNext;
      logic [CNT_W-1:0] w_dcntNext;
      logic             w_rise;
      logic             w_fall;
      holdState_t       w_holdNext;
      logic [CNT_W-1:0] w_hcntNext;
      logic             w_repeatNext;

      // Any sample that agrees with the accepted level restarts the count.
      always_comb begin
         w_stateNext = r_state;
         w_dcntNext  = '0;
         if (r_sync2[g] != r_state) begin
            if (r_dcnt == DEB_LAST) begin
               w_stateNext = r_sync2[g];
            end else begin
               w_dcntNext = r_dcnt + 1'b1;
            end
         end
      end

      assign w_rise = w_stateNext & ~r_state;
      assign w_fall = ~w_stateNext & r_state;

      // The FSM reacts to the debounced edge on the same clock that updates
      // btn_state, so a release always wins over a repeat due that cycle.
      always_comb begin
         w_holdNext   = r_hold;
         w_hcntNext   = r_hcnt;
         w_repeatNext = 1'b0;
         if (w_fall) begin
            w_holdNext = IDLE;
            w_hcntNext = '0;
         end else begin
            case (r_hold)
               IDLE: begin
                  if (w_rise) begin
                     w_holdNext = DELAY;
                     w_hcntNext = '0;
                  end
               end
               DELAY: begin
                  if (r_hcnt == HOLD_LAST) begin
                     w_holdNext   = REPEAT;
                     w_hcntNext   = '0;
                     w_repeatNext = 1'b1;
                  end else begin
                     w_hcntNext = r_hcnt + 1'b1;
                  end
               end
               REPEAT: begin
                  if (r_hcnt == REPEAT_LAST) begin
                     w_hcntNext   = '0;
                     w_repeatNext = 1'b1;
                  end else begin
                     w_hcntNext = r_hcnt + 1'b1;
                  end
               end
               default: begin
                  w_holdNext = IDLE;
                  w_hcntNext = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_hold    <= IDLE;
         end else begin
            r_state   <= w_stateNext;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_repeat  <= w_repeatNext;
            r_dcnt    <= w_dcntNext;
            r_hcnt    <= w_hcntNext;
            r_hold    <= w_holdNext;
         end
      end

      assign btn_state[g]   = r_state;
      assign btn_press[g]   = r_press;
      assign btn_release[g] = r_release;
      assign btn_repeat[g]  = r_repeat;
   end

   assign any_press = |btn_press;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader (N=2, DEB=4, HOLD=20, REPEAT=8):
// stimulus queues expected output events, a monitor pops them as they appear.
module tb_button_reader;

   localparam int N    = 2;
   localparam int DEB  = 4;
   localparam int HOLD = 20;
   localparam int REP  = 8;
   localparam int LAT  = DEB + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] btn_in;
   logic [N-1:0] btn_state;
   logic [N-1:0] btn_press;
   logic [N-1:0] btn_release;
   logic [N-1:0] btn_repeat;
   logic         any_press;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int           cyc;
      logic [N-1:0] st;
      logic [N-1:0] pr;
      logic [N-1:0] rl;
      logic [N-1:0] rp;
   } event_t;

   event_t sbq[$];

   button_reader #(
      .N(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .btn_state(btn_state),
      .btn_press(btn_press),
      .btn_release(btn_release),
      .btn_repeat(btn_repeat),
      .any_press(any_press)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every cycle with a pulse on any event output must match the queue head.
   always @(negedge clk) begin
      if ((|btn_press) || (|btn_release) || (|btn_repeat) || any_press) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event cyc=%0d got st=%b pr=%b rl=%b rp=%b any=%b, required no event",
                     cyc, btn_state, btn_press, btn_release, btn_repeat, any_press);
         end else begin
            event_t e;
            e = sbq.pop_front();
            if (e.cyc != cyc || btn_state !== e.st || btn_press !== e.pr ||
                btn_release !== e.rl || btn_repeat !== e.rp || any_press !== (|e.pr)) begin
               failures++;
               $display("[TB] FAIL event cyc=%0d got st=%b pr=%b rl=%b rp=%b any=%b, required cyc=%0d st=%b pr=%b rl=%b rp=%b any=%b",
                        cyc, btn_state, btn_press, btn_release, btn_repeat, any_press,
                        e.cyc, e.st, e.pr, e.rl, e.rp, |e.pr);
            end
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [N-1:0] v);
      btn_in = v;
   endtask

   task automatic pushEvent(input int c, input logic [N-1:0] st, input logic [N-1:0] pr,
                            input logic [N-1:0] rl, input logic [N-1:0] rp);
      event_t e;
      e.cyc = c;
      e.st  = st;
      e.pr  = pr;
      e.rl  = rl;
      e.rp  = rp;
      sbq.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [N-1:0] st, input logic [N-1:0] pr,
                              input logic [N-1:0] rl, input logic [N-1:0] rp, input logic anyp);
      checks++;
      if (btn_state !== st || btn_press !== pr || btn_release !== rl ||
          btn_repeat !== rp || any_press !== anyp) begin
         failures++;
         $display("[TB] FAIL %s cyc=%0d got st=%b pr=%b rl=%b rp=%b any=%b, required st=%b pr=%b rl=%b rp=%b any=%b",
                  name, cyc, btn_state, btn_press, btn_release, btn_repeat, any_press,
                  st, pr, rl, rp, anyp);
      end
   endtask

   initial begin
      int   t;
      logic pat [9];
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      // Reset, then idle with no activity
      rst    = 1'b1;
      btn_in = '0;
      waitCycles(3);
      checkOutput("reset_state", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      rst = 1'b0;
      waitCycles(10);
      checkOutput("idle_after_reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      // Clean press and release on bit 0
      t = cyc;
      applyStimulus(2'b01);
      pushEvent(t + LAT, 2'b01, 2'b01, 2'b00, 2'b00);
      waitCycles(7);
      checkOutput("press_one_cycle", 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      waitCycles(3);
      applyStimulus(2'b00);
      pushEvent(t + 10 + LAT, 2'b00, 2'b00, 2'b01, 2'b00);
      waitCycles(10);
      checkOutput("after_release", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      // Bouncy press: only the final 0->1 survives
      t = cyc;
      pushEvent(t + 8 + LAT, 2'b01, 2'b01, 2'b00, 2'b00);
      for (int i = 0; i < 9; i++) begin
         applyStimulus({1'b0, pat[i]});
         waitCycles(1);
      end
      waitCycles(11);
      applyStimulus(2'b00);
      pushEvent(t + 20 + LAT, 2'b00, 2'b00, 2'b01, 2'b00);
      waitCycles(10);

      // Glitch one cycle shorter than the debounce window
      applyStimulus(2'b10);
      waitCycles(3);
      applyStimulus(2'b00);
      waitCycles(12);
      checkOutput("glitch_ignored", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      // Hold bit 1; release lands exactly where a repeat would have been
      t = cyc;
      applyStimulus(2'b10);
      pushEvent(t + LAT, 2'b10, 2'b10, 2'b00, 2'b00);
      for (int k = 0; k < 5; k++)
         pushEvent(t + LAT + HOLD + k * REP, 2'b10, 2'b00, 2'b00, 2'b10);
      waitCycles(60);
      applyStimulus(2'b00);
      pushEvent(t + 60 + LAT, 2'b00, 2'b00, 2'b10, 2'b00);
      waitCycles(20);

      // Reset while in REPEAT with the button still held
      t = cyc;
      applyStimulus(2'b01);
      pushEvent(t + LAT, 2'b01, 2'b01, 2'b00, 2'b00);
      pushEvent(t + LAT + HOLD, 2'b01, 2'b00, 2'b00, 2'b01);
      pushEvent(t + LAT + HOLD + REP, 2'b01, 2'b00, 2'b00, 2'b01);
      waitCycles(38);
      rst = 1'b1;
      waitCycles(1);
      checkOutput("mid_repeat_reset", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      rst = 1'b0;
      pushEvent(t + 39 + LAT, 2'b01, 2'b01, 2'b00, 2'b00);
      pushEvent(t + 39 + LAT + HOLD, 2'b01, 2'b00, 2'b00, 2'b01);
      pushEvent(t + 39 + LAT + HOLD + REP, 2'b01, 2'b00, 2'b00, 2'b01);
      waitCycles(36);
      applyStimulus(2'b00);
      pushEvent(t + 75 + LAT, 2'b00, 2'b00, 2'b01, 2'b00);
      waitCycles(15);

      // Simultaneous press, then release bit 0 while bit 1 keeps repeating
      t = cyc;
      applyStimulus(2'b11);
      pushEvent(t + LAT, 2'b11, 2'b11, 2'b00, 2'b00);
      pushEvent(t + LAT + HOLD, 2'b11, 2'b00, 2'b00, 2'b11);
      pushEvent(t + LAT + HOLD + REP, 2'b11, 2'b00, 2'b00, 2'b11);
      waitCycles(36);
      applyStimulus(2'b10);
      pushEvent(t + 36 + LAT, 2'b10, 2'b00, 2'b01, 2'b10);
      pushEvent(t + LAT + HOLD + 3 * REP, 2'b10, 2'b00, 2'b00, 2'b10);
      pushEvent(t + LAT + HOLD + 4 * REP, 2'b10, 2'b00, 2'b00, 2'b10);
      waitCycles(24);
      applyStimulus(2'b00);
      pushEvent(t + 60 + LAT, 2'b00, 2'b00, 2'b10, 2'b00);
      waitCycles(20);
      checkOutput("final_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("[TB] FAIL missing_events got %0d still queued, required 0 (next at cyc=%0d)",
                  sbq.size(), sbq[0].cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
